// File: rtl/gray_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_chk_pkg
// Brief    : Shared state encoding and default widths for the Gray checker.
// Revision : 1.0
// ============================================================================
package gray_chk_pkg;

    localparam int DEF_N  = 8;
    localparam int DEF_CW = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage : gray_chk_pkg
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : gray_to_bin
// Brief    : Combinational N-bit Gray to binary decode.
// Revision : 1.0
// ============================================================================
module gray_to_bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < N; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule : gray_to_bin
`default_nettype wire

// File: rtl/gray_chk_nbits.sv
`default_nettype none
// ============================================================================
// Module   : gray_chk_nbits
// Brief    : Gray counter self-check: decode, +1 step check, wrap and error
//            reporting. Define GRAY_CHK_PIPE_EN for an input register stage.
// Revision : 1.0
// ============================================================================
module gray_chk_nbits
    import gray_chk_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  gray_in,
    input  logic          gray_vld,
    input  logic          clr,
    output logic [N-1:0]  bin_out,
    output logic          bin_vld,
    output logic          wrap,
    output logic          err,
    output logic          locked,
    output logic          fault,
    output logic [CW-1:0] err_cnt
);

    logic [N-1:0]  gray_s;
    logic          vld_s;
    logic [N-1:0]  bin_w;
    logic [N-1:0]  exp_w;

    state_t        state_q, state_d;
    logic [N-1:0]  prev_q, prev_d;
    logic [N-1:0]  bin_q, bin_d;
    logic          bin_vld_q, bin_vld_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

`ifdef GRAY_CHK_PIPE_EN
    logic [N-1:0]  gray_q;
    logic          vld_q;

    // clr flushes the staged sample so both builds drop the same samples.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            gray_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            gray_q <= gray_in;
            vld_q  <= gray_vld;
        end
    end

    assign gray_s = gray_q;
    assign vld_s  = vld_q;
`else
    assign gray_s = gray_in;
    assign vld_s  = gray_vld;
`endif

    gray_to_bin #(
        .N (N)
    ) u_dec (
        .gray_i (gray_s),
        .bin_o  (bin_w)
    );

    assign exp_w = prev_q + N'(1);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        bin_d     = bin_q;
        bin_vld_d = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        if (clr) begin
            state_d = SYNC;
            cnt_d   = '0;
        end else if (vld_s) begin
            bin_d     = bin_w;
            bin_vld_d = 1'b1;
            prev_d    = bin_w;
            case (state_q)
                TRACK, FAULT: begin
                    wrap_d = (&prev_q) && (bin_w == '0);
                    if (bin_w != exp_w) begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = TRACK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SYNC;
            prev_q    <= '0;
            bin_q     <= '0;
            bin_vld_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            bin_q     <= bin_d;
            bin_vld_q <= bin_vld_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bin_out = bin_q;
    assign bin_vld = bin_vld_q;
    assign wrap    = wrap_q;
    assign err     = err_q;
    assign locked  = (state_q == TRACK);
    assign fault   = (state_q == FAULT);
    assign err_cnt = cnt_q;

endmodule : gray_chk_nbits
`default_nettype wire

// File: tb/tb_gray_chk_nbits.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_chk_nbits
// Brief    : Randomized self-checking bench with a behavioural checker model;
//            a second instance with CW=2 shares the stimulus.
// Revision : 1.0
// ============================================================================
module tb_gray_chk_nbits;

    localparam int N  = 8;
    localparam int CW = 16;
`ifdef GRAY_CHK_PIPE_EN
    localparam int LAT  = 2;
    localparam bit PIPE = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit PIPE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          gray_vld;
    logic          clr;
    logic [N-1:0]  gray_in;

    logic [N-1:0]  bin_out,  bin_out2;
    logic          bin_vld,  bin_vld2;
    logic          wrap,     wrap2;
    logic          err,      err2;
    logic          locked,   locked2;
    logic          fault,    fault2;
    logic [CW-1:0] err_cnt;
    logic [1:0]    err_cnt2;

    gray_chk_nbits #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_vld(gray_vld), .clr(clr),
        .bin_out(bin_out), .bin_vld(bin_vld), .wrap(wrap), .err(err),
        .locked(locked), .fault(fault), .err_cnt(err_cnt)
    );

    gray_chk_nbits #(.N(N), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_vld(gray_vld), .clr(clr),
        .bin_out(bin_out2), .bin_vld(bin_vld2), .wrap(wrap2), .err(err2),
        .locked(locked2), .fault(fault2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0=sync, 1=track, 2=fault; counts are unbounded ints.
    int m_state, m_prev, m_bin, m_cnt;
    bit m_vld, m_wrap, m_err;
    bit st_v;
    int st_g;

    wire [N+5+CW-1:0] act1 = {bin_out, bin_vld, wrap, err, locked, fault, err_cnt};
    wire [N+5+1:0]    act2 = {bin_out2, bin_vld2, wrap2, err2, locked2, fault2, err_cnt2};

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 255;
    endfunction

    function automatic int from_gray(input int g);
        for (int b = 0; b < 256; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    function automatic logic [N+5+CW-1:0] model_vec1();
        int sat;
        sat = (m_cnt > 65535) ? 65535 : m_cnt;
        return {N'(m_bin), m_vld, m_wrap, m_err, (m_state == 1), (m_state == 2), CW'(sat)};
    endfunction

    function automatic logic [N+5+1:0] model_vec2();
        int sat;
        sat = (m_cnt > 3) ? 3 : m_cnt;
        return {N'(m_bin), m_vld, m_wrap, m_err, (m_state == 1), (m_state == 2), 2'(sat)};
    endfunction

    task automatic cycle(input bit r, input bit v, input bit c, input int g);
        bit cv;
        int cg, b;
        @(negedge clk);
        rst      = r;
        gray_vld = v;
        clr      = c;
        gray_in  = N'(g);
        if (r) begin
            m_state = 0; m_prev = 0; m_bin = 0; m_cnt = 0;
            m_vld = 0; m_wrap = 0; m_err = 0; st_v = 0; st_g = 0;
        end else begin
            if (PIPE) begin
                cv = st_v && !c; cg = st_g;
                st_v = v && !c;  st_g = g;
            end else begin
                cv = v && !c; cg = g;
            end
            m_vld = 0; m_wrap = 0; m_err = 0;
            if (c) begin
                m_state = 0; m_cnt = 0;
            end else if (cv) begin
                b = from_gray(cg);
                m_bin = b; m_vld = 1;
                if (m_state == 0) begin
                    m_state = 1;
                end else begin
                    m_wrap = (m_prev == 255) && (b == 0);
                    if (b != ((m_prev + 1) % 256)) begin
                        m_err = 1; m_cnt++; m_state = 2;
                    end
                end
                m_prev = b;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 5);
        checks++;
        if ({act1, act2} !== '0) begin
            errors++;
            $display("FAIL reset: got %h expected 0", {act1, act2});
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_directed();
        int seq[4] = '{'h80, 'h00, 'h01, 'h03};
        int wraps = 0, errs = 0;
        for (int i = 0; i < 4 + LAT + 1; i++) begin
            if (i < 4) cycle(0, 1, 0, seq[i]);
            else       cycle(0, 0, 0, 0);
            wraps += int'(wrap);
            errs  += int'(err);
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL directed cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
        checks++;
        if (wraps != 1 || errs != 0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL directed_summary: got wraps=%0d errs=%0d locked=%b expected 1 0 1", wraps, errs, locked);
        end
    endtask

    task automatic test_latency();
        int lat = 0;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, to_gray(42));
        for (int k = 1; k <= 8; k++) begin
            if (bin_vld === 1'b1) begin
                lat = k;
                break;
            end
            cycle(0, 0, 0, 0);
        end
        checks++;
        if (lat != LAT || bin_out !== 8'd42) begin
            errors++;
            $display("FAIL latency: got lat=%0d bin=%h expected lat=%0d bin=2a", lat, bin_out, LAT);
        end
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
    endtask

    task automatic test_sweep();
        int start = $urandom_range(0, 255);
        int wraps = 0;
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 257 + LAT + 1; i++) begin
            if (i < 257) cycle(0, 1, 0, to_gray((start + i) % 256));
            else         cycle(0, 0, 0, 0);
            wraps += int'(wrap);
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL sweep cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
        checks++;
        if (wraps != 1 || err_cnt !== '0) begin
            errors++;
            $display("FAIL sweep_summary: got wraps=%0d err_cnt=%0d expected 1 0", wraps, err_cnt);
        end
    endtask

    task automatic test_skip();
        int seq[4] = '{4, 5, 7, 8};
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 4 + LAT; i++) begin
            if (i < 4) cycle(0, 1, 0, to_gray(seq[i]));
            else       cycle(0, 0, 0, 0);
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL skip cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
        checks++;
        if (err_cnt !== 16'd1 || fault !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL skip_summary: got cnt=%0d fault=%b locked=%b expected 1 1 0", err_cnt, fault, locked);
        end
    endtask

    task automatic test_repeat();
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 2 + LAT; i++) begin
            if (i < 2) cycle(0, 1, 0, to_gray(10));
            else       cycle(0, 0, 0, 0);
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL repeat cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
        checks++;
        if (err_cnt !== 16'd1 || fault !== 1'b1) begin
            errors++;
            $display("FAIL repeat_summary: got cnt=%0d fault=%b expected 1 1", err_cnt, fault);
        end
    endtask

    task automatic test_clr_vld();
        cycle(0, 1, 0, to_gray(20));
        cycle(0, 1, 0, to_gray(30));
        cycle(0, 1, 1, to_gray(31));
        checks++;
        if (locked !== 1'b0 || fault !== 1'b0 || err_cnt !== '0 || bin_vld !== 1'b0) begin
            errors++;
            $display("FAIL clr_vld: got locked=%b fault=%b cnt=%0d vld=%b expected 0 0 0 0", locked, fault, err_cnt, bin_vld);
        end
        cycle(0, 1, 0, to_gray(99));
        for (int i = 0; i < LAT + 1; i++) begin
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL clr_vld_next cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
            cycle(0, 0, 0, 0);
        end
        checks++;
        if (locked !== 1'b1 || err_cnt !== '0 || bin_out !== 8'd99) begin
            errors++;
            $display("FAIL clr_vld_accept: got locked=%b cnt=%0d bin=%0d expected 1 0 99", locked, err_cnt, bin_out);
        end
    endtask

    task automatic test_saturate();
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 6 + LAT; i++) begin
            if (i < 6) cycle(0, 1, 0, to_gray(i * 5));
            else       cycle(0, 0, 0, 0);
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL saturate cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
        checks++;
        if (err_cnt2 !== 2'd3 || err_cnt !== 16'd5) begin
            errors++;
            $display("FAIL saturate_summary: got cnt2=%0d cnt=%0d expected 3 5", err_cnt2, err_cnt);
        end
    endtask

    task automatic test_random();
        int cur = $urandom_range(0, 255);
        bit v, c;
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            if (v) begin
                if ($urandom_range(0, 9) == 0) cur = $urandom_range(0, 255);
                else                           cur = (cur + 1) % 256;
            end
            cycle(0, v, c, v ? to_gray(cur) : $urandom_range(0, 255));
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
    endtask

    task automatic test_rst_mid();
        cycle(0, 1, 0, to_gray(200));
        cycle(0, 1, 0, to_gray(203));
        cycle(1, 1, 0, to_gray(204));
        checks++;
        if ({act1, act2} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got %h expected 0", {act1, act2});
        end
        for (int i = 0; i < 3 + LAT; i++) begin
            if (i < 3) cycle(0, 1, 0, to_gray(60 + i));
            else       cycle(0, 0, 0, 0);
            checks++;
            if ({act1, act2} !== {model_vec1(), model_vec2()}) begin
                errors++;
                $display("FAIL rst_resume cyc %0d: got %h expected %h", i, {act1, act2}, {model_vec1(), model_vec2()});
            end
        end
    endtask

    initial begin
        rst = 1'b1; gray_vld = 1'b0; clr = 1'b0; gray_in = '0;
        m_state = 0; m_prev = 0; m_bin = 0; m_cnt = 0;
        m_vld = 0; m_wrap = 0; m_err = 0; st_v = 0; st_g = 0;
        test_reset();
        test_directed();
        test_latency();
        test_sweep();
        test_skip();
        test_repeat();
        test_clr_vld();
        test_saturate();
        test_random();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gray_chk_nbits
`default_nettype wire
